// File: rtl/rocketcpu_param_smoother.sv
// One-pole parameter smoother: per sample tick, walks every channel once and moves it toward its snapshotted target.
// Optional feature macro PARAM_SMOOTHER_SNAP_EN adds i_snap (jump straight to target on that pass).
module rocketcpu_param_smoother #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int SHIFT    = 6
) (
   input  logic                      i_wb_clk,
   input  logic                      i_rst,
   input  logic                      i_sample_tick,
`ifdef PARAM_SMOOTHER_SNAP_EN
   input  logic                      i_snap,
`endif
   input  logic [CHANNELS*WIDTH-1:0] i_target,
   output logic [CHANNELS*WIDTH-1:0] o_param,
   output logic [CHANNELS-1:0]       o_settled,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_overrun
);

   localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   state_t              state, state_next;
   logic [IDXW-1:0]     idx_q;
   logic [WIDTH-1:0]    y_q   [CHANNELS];
   logic [WIDTH-1:0]    tgt_q [CHANNELS];
   logic [CHANNELS-1:0] settled_q;
   logic                overrun_q;
`ifdef PARAM_SMOOTHER_SNAP_EN
   logic                snap_q;
`endif

   logic [WIDTH-1:0]        cur_y, cur_t, y_new;
   logic signed [WIDTH:0]   diff, step;

   always_ff @(posedge i_wb_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_sample_tick) state_next = UPDATE;
         UPDATE:  if (idx_q == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Difference is taken one bit wider so full-scale swings cannot wrap; the
   // step never overshoots, so the final add fits back into WIDTH bits.
   always_comb begin
      cur_y = y_q[idx_q];
      cur_t = tgt_q[idx_q];
      diff  = $signed({cur_t[WIDTH-1], cur_t}) - $signed({cur_y[WIDTH-1], cur_y});
      step  = diff >>> SHIFT;
      if (step == '0 && diff != '0)
         step = diff[WIDTH] ? '1 : (WIDTH+1)'(1);
`ifdef PARAM_SMOOTHER_SNAP_EN
      y_new = snap_q ? cur_t : cur_y + step[WIDTH-1:0];
`else
      y_new = cur_y + step[WIDTH-1:0];
`endif
   end

   always_ff @(posedge i_wb_clk or posedge i_rst) begin
      if (i_rst) begin
         idx_q     <= '0;
         settled_q <= '0;
         overrun_q <= 1'b0;
`ifdef PARAM_SMOOTHER_SNAP_EN
         snap_q    <= 1'b0;
`endif
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            y_q[k]   <= '0;
            tgt_q[k] <= '0;
         end
      end else begin
         if (i_sample_tick && state != IDLE)
            overrun_q <= 1'b1;
         case (state)
            IDLE: begin
               if (i_sample_tick) begin
                  idx_q <= '0;
`ifdef PARAM_SMOOTHER_SNAP_EN
                  snap_q <= i_snap;
`endif
                  for (int unsigned k = 0; k < CHANNELS; k++)
                     tgt_q[k] <= i_target[k*WIDTH +: WIDTH];
               end
            end
            UPDATE: begin
               y_q[idx_q]       <= y_new;
               settled_q[idx_q] <= (y_new == cur_t);
               idx_q            <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < CHANNELS; k++)
         o_param[k*WIDTH +: WIDTH] = y_q[k];
   end

   assign o_settled = settled_q;
   assign o_overrun = overrun_q;
   assign o_busy    = (state != IDLE);
   assign o_done    = (state == DONE);

endmodule

// File: tb/tb_rocketcpu_param_smoother.sv
// Scoreboard bench for rocketcpu_param_smoother (CHANNELS=4, WIDTH=32, SHIFT=6); expected values are hand-computed.
module tb_rocketcpu_param_smoother;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic [127:0] target;
`ifdef PARAM_SMOOTHER_SNAP_EN
   logic         snap;
`endif
   logic [127:0] param;
   logic [3:0]   settled;
   logic         busy, done, overrun;

   rocketcpu_param_smoother #(.CHANNELS(4), .WIDTH(32), .SHIFT(6)) dut (
      .i_wb_clk      (clk),
      .i_rst         (rst),
      .i_sample_tick (tick),
`ifdef PARAM_SMOOTHER_SNAP_EN
      .i_snap        (snap),
`endif
      .i_target      (target),
      .o_param       (param),
      .o_settled     (settled),
      .o_busy        (busy),
      .o_done        (done),
      .o_overrun     (overrun)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] p;
      logic [3:0]   s;
      int unsigned  due;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   function automatic logic [127:0] pk(input logic [31:0] c3, input logic [31:0] c2,
                                       input logic [31:0] c1, input logic [31:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   // Monitor: every o_done pulse consumes one expected pass result.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL spurious_done: o_done=1 with no pass pending, required 0");
         end else begin
            e = sb.pop_front();
            check("latency", 128'(cyc), 128'(e.due));
            check("param", param, e.p);
            check("settled", 128'(settled), 128'(e.s));
            check("busy_at_done", 128'(busy), 128'd1);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL done_timeout: %0d pass(es) outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic pass(input logic [127:0] p, input logic [3:0] s);
      @(negedge clk);
      tick = 1'b1;
      sb.push_back('{p: p, s: s, due: cyc + 5});
      @(negedge clk);
      tick = 1'b0;
      check("busy_in_pass", 128'(busy), 128'd1);
      drain();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      tick   = 1'b0;
      target = '0;
`ifdef PARAM_SMOOTHER_SNAP_EN
      snap   = 1'b0;
`endif
      #1;
      check("rst_param", param, '0);
      check("rst_settled", 128'(settled), '0);
      check("rst_flags", 128'({busy, done, overrun}), '0);
      @(negedge clk);
      rst = 1'b0;

      // Single large step on ch0
      target = pk(32'h0, 32'h0, 32'h0, 32'h0000_1000);
      pass(pk(32'h0, 32'h0, 32'h0, 32'h0000_0040), 4'b1110);
      @(negedge clk);
      check("idle_busy", 128'(busy), '0);

      // Minimum-step rule: ch1 creeps 1..5 then holds
      do_reset();
      target = pk(32'h0, 32'h0, 32'd5, 32'h0);
      for (int p = 1; p <= 6; p++)
         pass(pk(32'h0, 32'h0, (p < 5) ? 32'(p) : 32'd5, 32'h0), (p >= 5) ? 4'b1111 : 4'b1101);

      // Negative targets and full-scale swings
      do_reset();
      target = pk(32'h8000_0000, 32'hFFFF_F000, 32'h0, 32'h0);
      pass(pk(32'hFE00_0000, 32'hFFFF_FFC0, 32'h0, 32'h0), 4'b0011);
      target = pk(32'h7FFF_FFFF, 32'hFFFF_FFC0, 32'h0, 32'h0);
      pass(pk(32'h0007_FFFF, 32'hFFFF_FFC0, 32'h0, 32'h0), 4'b0111);
      target = pk(32'h8000_0000, 32'hFFFF_FFC0, 32'h0, 32'h0);
      pass(pk(32'hFE07_DFFF, 32'hFFFF_FFC0, 32'h0, 32'h0), 4'b0111);

      // Overrun: second tick during UPDATE is ignored, target change does not tear
      do_reset();
      target = pk(32'h0, 32'h0, 32'h0, 32'h0000_1000);
      @(negedge clk);
      tick = 1'b1;
      sb.push_back('{p: pk(32'h0, 32'h0, 32'h0, 32'h40), s: 4'b1110, due: cyc + 5});
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      tick = 1'b1;
      target = pk(32'h0, 32'h0, 32'h0, 32'h0000_2000);
      @(negedge clk);
      tick = 1'b0;
      check("overrun_set", 128'(overrun), 128'd1);
      drain();
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("no_second_pass", 128'(busy), '0);
      pass(pk(32'h0, 32'h0, 32'h0, 32'h0000_00BF), 4'b1110);
      check("overrun_sticky", 128'(overrun), 128'd1);

      // Reset while UPDATE sits at index 2
      target = pk(32'h0, 32'h0, 32'h0000_0300, 32'h0000_1000);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_pass_param", param, pk(32'h0, 32'h0, 32'h0000_000C, 32'h0000_00FC));
      #2 rst = 1'b1;
      #1;
      check("midrst_param", param, '0);
      check("midrst_settled", 128'(settled), '0);
      check("midrst_flags", 128'({busy, done, overrun}), '0);
      @(negedge clk);
      rst = 1'b0;
      target = pk(32'h0, 32'h0, 32'h0, 32'h0000_1000);
      pass(pk(32'h0, 32'h0, 32'h0, 32'h0000_0040), 4'b1110);

`ifdef PARAM_SMOOTHER_SNAP_EN
      do_reset();
      target = pk(32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010);
      snap = 1'b1;
      pass(pk(32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010), 4'b1111);
      snap = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rocketcpu_param_smoother.md
ROCKETCPU_PARAM_SMOOTHER -- requirements
Module: rocketcpu_param_smoother

Interface
REQ-001 Parameter CHANNELS, default 4: number of smoothed parameter channels (1..16).
REQ-002 Parameter WIDTH, default 32: bits per channel, two's-complement signed.
REQ-003 Parameter SHIFT, default 6: one-pole smoothing shift (1..WIDTH-1).
REQ-004 i_wb_clk  in  1: the single clock; all logic on its rising edge.
REQ-005 i_rst  in  1: reset, asynchronous, active-high.
REQ-006 i_sample_tick  in  1: one-cycle pulse at audio sample rate.
REQ-007 i_target  in  CHANNELS*WIDTH: target words from the audio register file; channel k in bits [k*WIDTH +: WIDTH].
REQ-008 o_param  out  CHANNELS*WIDTH: smoothed values to the DSP path, same packing as i_target.
REQ-009 o_settled  out  CHANNELS: bit k high when o_param channel k equals its latched target.
REQ-010 o_busy  out  1: high while a smoothing pass is in progress.
REQ-011 o_done  out  1: one-cycle pulse at the end of each pass.
REQ-012 o_overrun  out  1: sticky flag, tick received while busy.

Function
REQ-013 FSM states IDLE, UPDATE, DONE; reset state IDLE.
REQ-014 IDLE: on i_sample_tick, snapshot all of i_target into internal target registers, clear channel index to 0, go to UPDATE; otherwise stay.
REQ-015 UPDATE: one channel per cycle, index 0 to CHANNELS-1; after channel CHANNELS-1, go to DONE.
REQ-016 DONE: assert o_done for exactly one cycle, return to IDLE; total latency tick to o_done = CHANNELS+1 cycles.
REQ-017 o_busy high in UPDATE and DONE, low in IDLE.
REQ-018 Per-channel update: diff = target - y computed at WIDTH+1 bits; step = diff arithmetic-shifted right by SHIFT.
REQ-019 Boundary: if step == 0 and diff != 0, step becomes +1 (diff > 0) or -1 (diff < 0), guaranteeing convergence.
REQ-020 y_new = y + step; y_new always lies between y and target inclusive, so no overflow or wrap occurs at any WIDTH extreme.
REQ-021 o_settled[k] updated in the same cycle as channel k: high iff y_new == target.
REQ-022 Changes on i_target after the snapshot do not affect the current pass (no tearing).
REQ-023 i_sample_tick in UPDATE or DONE is ignored (no restart, no queueing) and sets o_overrun; o_overrun clears only on reset.
REQ-024 i_sample_tick in IDLE in the same cycle DONE exits is impossible by construction; a tick in DONE counts as overrun.
REQ-025 o_param channels not currently being updated hold their value.

Reset
REQ-026 On i_rst asserted, immediately: o_param all 0, o_settled all 0, o_busy 0, o_done 0, o_overrun 0, target snapshot 0, index 0, FSM IDLE.
REQ-027 Reset mid-pass abandons the pass; the first tick after release starts a full pass from channel 0.

Configuration
REQ-028 Macro PARAM_SMOOTHER_SNAP_EN: when defined, input port i_snap (1 bit) exists; if i_snap is high with the accepted tick, that pass sets y_new = target for every channel (all o_settled high at o_done).
REQ-029 Without PARAM_SMOOTHER_SNAP_EN: no i_snap port; every pass uses REQ-018..REQ-020 smoothing only.

Verification (CHANNELS=4, WIDTH=32, SHIFT=6)
REQ-030 Reset, ch0 target 0x0000_1000, others 0, one tick -> o_done 5 cycles after tick; ch0 = 0x0000_0040; o_settled = 4'b1110.
REQ-031 From 0, ch1 target 5, repeated ticks -> ch1 steps 1,2,3,4,5 (minimum-step rule); o_settled[1] high after fifth pass, value then stable.
REQ-032 From 0, ch2 target 0xFFFF_F000 -> after one pass ch2 = 0xFFFF_FFC0; from 0x7FFF_FFFF toward 0x8000_0000 -> value decreases monotonically, never wraps.
REQ-033 Tick, second tick 2 cycles later -> second ignored, o_overrun = 1 and stays 1, single o_done pulse, outputs match one pass.
REQ-034 i_rst asserted during UPDATE at index 2 -> all outputs 0 in the same cycle; next tick gives a full 5-cycle pass.
REQ-035 With PARAM_SMOOTHER_SNAP_EN, targets {0x10, -0x10, 0x7FFF_FFFF, 0}, i_snap=1 with tick -> o_param equals targets at o_done, o_settled = 4'b1111.
